// File: rtl/pipelined_cla_adder_pkg.sv
// pipelined_cla_adder_pkg: shared ALU constants for the pipelined CLA adder/subtractor
package pipelined_cla_adder_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int GROUP_DEF = 4;
  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;
endpackage

// File: rtl/pipelined_cla_adder_if.sv
// pipelined_cla_adder_if: operand/result valid-ready bundle for the pipelined adder
interface pipelined_cla_adder_if import pipelined_cla_adder_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic sub;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] s;
  logic cout;
  logic ovf;
  logic zero;
  modport master (
    output in_valid, a, b, sub, out_ready,
    input in_ready, out_valid, s, cout, ovf, zero
  );
  modport slave (
    input in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_cla_adder_cla.sv
// pipelined_cla_adder_cla: 1-bit P/G/S cells and a grouped combinational carry-lookahead adder
module partial_full_adder1b (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic p,
  output logic g,
  output logic s
);
  assign p = a ^ b;
  assign g = a & b;
  assign s = p ^ c;
endmodule

module cla_half_adder #(
  parameter int N = 32,
  parameter int GROUP = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  localparam int NG = N / GROUP;
  logic [N-1:0] p, g, c;
  logic [NG:0] gc;
  logic gp_v, gg_v;
  for (genvar i = 0; i < N; i++) begin : g_bit
    partial_full_adder1b u_pfa (.a(a[i]), .b(b[i]), .c(c[i]), .p(p[i]), .g(g[i]), .s(s[i]));
  end
  // group P/G decide each group's carry-in; bit carries then expand inside the group
  always_comb begin
    gc = '0;
    c = '0;
    gp_v = 1'b1;
    gg_v = 1'b0;
    gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      gp_v = 1'b1;
      gg_v = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
        gg_v = g[k*GROUP+i] | (p[k*GROUP+i] & gg_v);
        gp_v = gp_v & p[k*GROUP+i];
      end
      gc[k+1] = gg_v | (gp_v & gc[k]);
      c[k*GROUP] = gc[k];
      for (int i = 1; i < GROUP; i++)
        c[k*GROUP+i] = g[k*GROUP+i-1] | (p[k*GROUP+i-1] & c[k*GROUP+i-1]);
    end
  end
  assign cout = gc[NG];
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: 2-stage valid/ready CLA adder/subtractor, low half then high half
module pipelined_cla_adder import pipelined_cla_adder_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GROUP = GROUP_DEF
) (
  input logic clk,
  input logic rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int H = WIDTH / 2;
  logic [WIDTH-1:0] b_eff;
  logic cin0, c_mid, c_hi, in_ready, s1_load, s2_load;
  logic [H-1:0] lo_sum, hi_sum;
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [H-1:0] lo_q, lo_d, a_hi_q, a_hi_d, b_hi_q, b_hi_d;
  logic c_mid_q, c_mid_d, lo_zero_q, lo_zero_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  assign cin0 = bus.sub == ALU_OP_SUB;
  assign b_eff = cin0 ? ~bus.b : bus.b;
  cla_half_adder #(.N(H), .GROUP(GROUP)) u_lo (
    .a(bus.a[H-1:0]), .b(b_eff[H-1:0]), .cin(cin0), .s(lo_sum), .cout(c_mid)
  );
  cla_half_adder #(.N(H), .GROUP(GROUP)) u_hi (
    .a(a_hi_q), .b(b_hi_q), .cin(c_mid_q), .s(hi_sum), .cout(c_hi)
  );
  // stage 2 frees up when its result is consumed, letting stage 1 refill in the same cycle
  always_comb begin
    s2_load = s1_valid_q & (~s2_valid_q | bus.out_ready);
    in_ready = ~s1_valid_q | s2_load;
    s1_load = bus.in_valid & in_ready;
    s1_valid_d = s1_load | (s1_valid_q & ~s2_load);
    s2_valid_d = s2_load | (s2_valid_q & ~bus.out_ready);
    lo_d = s1_load ? lo_sum : lo_q;
    c_mid_d = s1_load ? c_mid : c_mid_q;
    a_hi_d = s1_load ? bus.a[WIDTH-1:H] : a_hi_q;
    b_hi_d = s1_load ? b_eff[WIDTH-1:H] : b_hi_q;
    lo_zero_d = s1_load ? (lo_sum == '0) : lo_zero_q;
    s_d = s2_load ? {hi_sum, lo_q} : s_q;
    cout_d = s2_load ? c_hi : cout_q;
    ovf_d = s2_load ? ((a_hi_q[H-1] == b_hi_q[H-1]) & (hi_sum[H-1] != a_hi_q[H-1])) : ovf_q;
    zero_d = s2_load ? (lo_zero_q & (hi_sum == '0)) : zero_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      lo_q <= '0;
      a_hi_q <= '0;
      b_hi_q <= '0;
      c_mid_q <= 1'b0;
      lo_zero_q <= 1'b0;
      s_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      lo_q <= lo_d;
      a_hi_q <= a_hi_d;
      b_hi_q <= b_hi_d;
      c_mid_q <= c_mid_d;
      lo_zero_q <= lo_zero_d;
      s_q <= s_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.s = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf = ovf_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed 64-bit vectors plus an exhaustive 4-bit sweep
module tb_pipelined_cla_adder;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  logic [6:0] q[$];
  logic [6:0] e;
  logic [4:0] r;
  logic [3:0] be;
  int idx = 0;
  int cyc = 0;
  pipelined_cla_adder_if #(.WIDTH(64)) m ();
  pipelined_cla_adder_if #(.WIDTH(4)) n ();
  pipelined_cla_adder #(.WIDTH(64), .GROUP(4)) u64 (.clk(clk), .rst_n(rst_n), .bus(m));
  pipelined_cla_adder #(.WIDTH(4), .GROUP(2)) u4 (.clk(clk), .rst_n(rst_n), .bus(n));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op64(input string tag, input logic [63:0] a, input logic [63:0] b, input logic sub,
                      input logic [63:0] es, input logic ec, input logic eo, input logic ez);
    @(negedge clk);
    m.in_valid = 1'b1;
    m.a = a;
    m.b = b;
    m.sub = sub;
    m.out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, m.in_ready, 1);
    @(negedge clk);
    m.in_valid = 1'b0;
    chk({tag, "_lat"}, m.out_valid, 0);
    @(negedge clk);
    chk({tag, "_v"}, m.out_valid, 1);
    chk({tag, "_s"}, m.s, es);
    chk({tag, "_cout_ovf_zero"}, {m.cout, m.ovf, m.zero}, {ec, eo, ez});
  endtask

  initial begin
    rst_n = 1'b0;
    m.in_valid = 1'b0; m.a = '0; m.b = '0; m.sub = 1'b0; m.out_ready = 1'b0;
    n.in_valid = 1'b0; n.a = '0; n.b = '0; n.sub = 1'b0; n.out_ready = 1'b0;
    #1;
    chk("rst_ov", m.out_valid, 0);
    chk("rst_s", m.s, 0);
    chk("rst_flags", {m.cout, m.ovf, m.zero}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_ird", m.in_ready, 1);
    op64("t1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    op64("t2a", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    op64("t2b", 64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0);
    op64("t3a", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    op64("t3b", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    op64("t4", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
    op64("tz", 64'd5, 64'd5, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
    op64("tnz", 64'h0000_0001_0000_0000, 64'd0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
    // backpressure: two accepts fill the pipe, then drain in order
    @(negedge clk);
    m.out_ready = 1'b0; m.in_valid = 1'b1; m.a = 64'd1; m.b = 64'd1; m.sub = 1'b0;
    @(negedge clk);
    chk("t5_rdy1", m.in_ready, 1);
    m.a = 64'd2; m.b = 64'd2;
    @(negedge clk);
    chk("t5_full", m.in_ready, 0);
    chk("t5_v", m.out_valid, 1);
    chk("t5_s0", m.s, 2);
    m.a = 64'd3; m.b = 64'd3;
    repeat (2) begin
      @(negedge clk);
      chk("t5_hold_rdy", m.in_ready, 0);
      chk("t5_hold_s", m.s, 2);
    end
    @(negedge clk);
    m.out_ready = 1'b1;
    #1 chk("t5_rdy2", m.in_ready, 1);
    chk("t5_s1", m.s, 2);
    @(negedge clk);
    chk("t5_s2_v", m.out_valid, 1);
    chk("t5_s2", m.s, 4);
    m.a = 64'd4; m.b = 64'd4;
    @(negedge clk);
    chk("t5_s3", m.s, 6);
    m.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_s4_v", m.out_valid, 1);
    chk("t5_s4", m.s, 8);
    @(negedge clk);
    chk("t5_empty", m.out_valid, 0);
    // reset with two ops in flight
    m.out_ready = 1'b0; m.in_valid = 1'b1; m.a = 64'd10; m.b = 64'd20;
    @(negedge clk);
    m.a = 64'd30; m.b = 64'd40;
    @(negedge clk);
    m.in_valid = 1'b0;
    chk("t6_pre", m.out_valid, 1);
    chk("t6_full", m.in_ready, 0);
    #2 rst_n = 1'b0;
    #1 chk("t6_async", m.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m.out_ready = 1'b1;
    #1 chk("t6_ird", m.in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("t6_nostale", m.out_valid, 0);
    end
    // exhaustive 4-bit sweep against the arithmetic reference
    while ((idx < 512 || q.size() > 0) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      n.in_valid = idx < 512;
      {n.sub, n.a, n.b} = 9'(idx);
      n.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (n.out_valid && n.out_ready) begin
        e = 'x;
        if (q.size() > 0) e = q.pop_front();
        chk("t7", {n.cout, n.ovf, n.zero, n.s}, e);
      end
      if (n.in_valid && n.in_ready) begin
        be = n.sub ? ~n.b : n.b;
        r = {1'b0, n.a} + {1'b0, be} + {4'd0, n.sub};
        q.push_back({r[4], (n.a[3] == be[3]) && (r[3] != n.a[3]), r[3:0] == 4'd0, r[3:0]});
        idx++;
      end
    end
    chk("t7_idx", idx, 512);
    chk("t7_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
